frac_clock_enable: RTL and testbench
====================================

Name: frac_clock_enable

Overview:
- Multi-channel fractional clock-enable generator; next generation of the differential clock divider.
- Each channel runs a Bresenham phase accumulator: tick rate = f_clk * INC / MOD. Ratios are runtime-programmable per channel.
- Produces single-cycle enable pulses for same-domain logic (no derived clocks), plus an optional toggled square output per channel for pins or legacy consumers.
- Sits at top level, fed by the master clock, driving PSG, CPU, VDP and UART enables.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
ACC_W, 24, width of inc, mod and accumulator per channel
DEFAULT_INC, 1, per-channel inc loaded at reset
DEFAULT_MOD, 6, per-channel mod loaded at reset (e.g. 21.477 MHz to 3.58 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_wr  in  1  single-cycle config write strobe
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of write
cfg_inc  in  ACC_W  new increment
cfg_mod  in  ACC_W  new modulus
ch_en  in  NUM_CH  per-channel run enable (level)
sync_restart  in  1  clears all accumulators and square outputs together
ce_out  out  NUM_CH  one-cycle enable pulse per channel
sq_out  out  NUM_CH  toggles on every ce pulse (f = f_ce/2)
cfg_err  out  NUM_CH  sticky: channel holds an invalid ratio

Behaviour:
- Reset (async assert, sync release): inc = DEFAULT_INC, mod = DEFAULT_MOD, acc = 0, ce_out = 0, sq_out = 0, cfg_err = validity of the defaults.
- Validity: valid iff mod != 0 and inc != 0 and inc < mod. An invalid channel never ticks, and its acc and sq are held at 0.
- Per cycle, for a channel that is valid, enabled, not being written and not restarting:
  - sum = acc + inc, computed ACC_W+1 wide (no overflow).
  - If sum >= mod: acc <= sum - mod, ce_out = 1, sq_out toggles.
  - Else: acc <= sum, ce_out = 0.
- Latency: ce_out is registered. The decision made in cycle n is visible in cycle n+1.
  - With inc=1, mod=6, the first pulse is on the 6th rising edge after reset release, then every 6 cycles.
- ch_en = 0: acc and sq freeze, ce_out = 0. Re-enable resumes from the frozen phase.
- Config write:
  - The addressed channel loads inc and mod, clears acc and sq, and updates cfg_err from the new values. It produces no tick in the write cycle.
  - Other channels are unaffected.
  - cfg_ch >= NUM_CH: write ignored.
- sync_restart: all acc, sq and ce cleared in that cycle. It has priority over accumulate.
  - If cfg_wr is in the same cycle, the write still loads inc/mod (acc cleared either way).
- cfg_err stays set until a valid write to that channel or reset.
- Long-run accuracy: over k*mod enabled cycles, exactly k*inc pulses. No drift.
- ce pulses never occur on consecutive cycles unless inc*2 > mod; inc = mod-1 gives back-to-back pulses except once per mod cycles.

Decomposition:
- Package clockdiv_pkg holds:
  - ACC_W default constant.
  - ch_cfg_t struct {inc, mod}.
  - Function ratio_valid(inc, mod).
  - Localparam helper computing CH_IDX_W = max(1, $clog2(NUM_CH)).
- Sub-module frac_ce_channel (one accumulator, inc/mod registers, sq toggle, err flag), generated NUM_CH times.
- The top level decodes cfg_ch and fans out sync_restart/ch_en.

Test Plan:
1. Reset defaults, ch_en all 1: each ce_out pulses at cycles 6, 12, 18…; sq_out period 12 cycles; cfg_err = 0.
2. Write ch1 inc=3, mod=7: ch1 gives exactly 3 pulses per 7-cycle window, repeating pattern, first pulse 3 cycles after the write; ch0 cadence is undisturbed.
3. Write ch2 inc=1000, mod=34921 (125 MHz to 3.58 MHz): over 349210 cycles, exactly 10000 pulses; inter-pulse spacing only 34 or 35.
4. Write ch3 mod=0, then inc=5, mod=5: cfg_err[3] = 1, no pulses, sq = 0. Then write inc=1, mod=2: cfg_err clears and pulses occur every 2nd cycle.
5. Mid-run: drop ch_en[0] for 4 cycles, then restore: the pulse is delayed exactly 4 cycles. Assert sync_restart with cfg_wr to ch1 in the same cycle: all sq = 0, all channels realign, ch1 takes its new ratio.
6. Assert reset asynchronously mid-pulse: ce_out/sq_out go to 0 immediately; after release, all channels return to the default inc=1, mod=6 cadence.

Source files
------------

// File: rtl/clockdiv_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Ratio checks are done at a fixed maximum width so one function serves any ACC_W.
package clockdiv_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int ACC_W_MAX = 32;

    typedef struct packed {
        logic [ACC_W_MAX-1:0] inc;
        logic [ACC_W_MAX-1:0] mod;
    } ch_cfg_t;

    function automatic logic ratio_valid(input ch_cfg_t c);
        return (c.mod != '0) && (c.inc != '0) && (c.inc < c.mod);
    endfunction

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frac_ce_channel.sv
// One Bresenham phase accumulator: registered enable pulse, square toggle,
// and an error flag that blocks ticking while the programmed ratio is invalid.
module frac_ce_channel
    import clockdiv_pkg::*;
#(
    parameter int          ACC_W       = ACC_W_DEF,
    parameter int unsigned DEFAULT_INC = 1,
    parameter int unsigned DEFAULT_MOD = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic             i_restart,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_inc,
    input  logic [ACC_W-1:0] i_mod,
    output logic             o_ce,
    output logic             o_sq,
    output logic             o_err
);

    localparam logic [ACC_W-1:0] L_INC = ACC_W'(DEFAULT_INC);
    localparam logic [ACC_W-1:0] L_MOD = ACC_W'(DEFAULT_MOD);
    localparam ch_cfg_t L_DEF = '{
        inc: ACC_W_MAX'(DEFAULT_INC),
        mod: ACC_W_MAX'(DEFAULT_MOD)
    };
    localparam logic L_ERR = !ratio_valid(L_DEF);

    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_mod;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_sq;
    logic             r_err;

    ch_cfg_t          w_new_cfg;
    logic [ACC_W:0]   w_sum;
    logic             w_hit;
    logic [ACC_W-1:0] w_acc_nxt;

    assign w_new_cfg = '{
        inc: ACC_W_MAX'(i_inc),
        mod: ACC_W_MAX'(i_mod)
    };

    // One extra bit so acc + inc never wraps before the compare
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_hit     = (w_sum >= {1'b0, r_mod});
    assign w_acc_nxt = w_hit ? ACC_W'(w_sum - {1'b0, r_mod})
                             : ACC_W'(w_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inc <= L_INC;
            r_mod <= L_MOD;
            r_acc <= '0;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
            r_err <= L_ERR;
        end else begin
            r_ce <= 1'b0;
            if (i_restart || i_wr) begin
                r_acc <= '0;
                r_sq  <= 1'b0;
                if (i_wr) begin
                    r_inc <= i_inc;
                    r_mod <= i_mod;
                    r_err <= !ratio_valid(w_new_cfg);
                end
            end else if (i_en && !r_err) begin
                r_acc <= w_acc_nxt;
                r_ce  <= w_hit;
                if (w_hit) begin
                    r_sq <= ~r_sq;
                end
            end
        end
    end

    assign o_ce  = r_ce;
    assign o_sq  = r_sq;
    assign o_err = r_err;

endmodule

// File: rtl/frac_clock_enable.sv
// Multi-channel fractional clock-enable generator (tick = f_clk * inc / mod).
// Decodes the config write address and fans restart/enable out to each channel.
module frac_clock_enable
    import clockdiv_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          ACC_W       = ACC_W_DEF,
    parameter int unsigned DEFAULT_INC = 1,
    parameter int unsigned DEFAULT_MOD = 6,
    localparam int         CH_IDX_W    = ch_idx_w(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic [ACC_W-1:0]    cfg_mod,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_restart,
    output logic [NUM_CH-1:0]   ce_out,
    output logic [NUM_CH-1:0]   sq_out,
    output logic [NUM_CH-1:0]   cfg_err
);

    logic [NUM_CH-1:0] w_wr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Out-of-range addresses match no channel and are dropped
        assign w_wr[g] = cfg_wr && (32'(cfg_ch) == 32'(g));

        frac_ce_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC),
            .DEFAULT_MOD (DEFAULT_MOD)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_wr      (w_wr[g]),
            .i_restart (sync_restart),
            .i_en      (ch_en[g]),
            .i_inc     (cfg_inc),
            .i_mod     (cfg_mod),
            .o_ce      (ce_out[g]),
            .o_sq      (sq_out[g]),
            .o_err     (cfg_err[g])
        );
    end

endmodule

// File: tb/tb_frac_clock_enable.sv
// Directed bench for frac_clock_enable with hand-computed pulse patterns.
module tb_frac_clock_enable;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_mod = '0;
    logic [NUM_CH-1:0] ch_en = '1;
    logic              sync_restart = 1'b0;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] sq_out;
    logic [NUM_CH-1:0] cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    frac_clock_enable #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .DEFAULT_INC (1),
        .DEFAULT_MOD (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_inc      (cfg_inc),
        .cfg_mod      (cfg_mod),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .ce_out       (ce_out),
        .sq_out       (sq_out),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input int ch, input int inc, input int md);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_inc = ACC_W'(inc);
        cfg_mod = ACC_W'(md);
        tick();
        cfg_wr  = 1'b0;
    endtask

    initial begin
        int g;
        int cnt;
        int last;
        int mins;
        int maxs;
        logic [13:0] pat1;
        logic [3:0]  e;

        // Reset state
        #2;
        chk("rst_ce", 32'(ce_out), 32'h0);
        chk("rst_sq", 32'(sq_out), 32'h0);
        chk("rst_err", 32'(cfg_err), 32'h0);
        tick();
        reset = 1'b0;

        // 1: default cadence, pulses on edges 6, 12, 18, 24
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk("t1_ce", 32'(ce_out), (k % 6 == 0) ? 32'hF : 32'h0);
            chk("t1_sq", 32'(sq_out), ((k / 6) % 2 == 1) ? 32'hF : 32'h0);
        end
        chk("t1_err", 32'(cfg_err), 32'h0);
        g = 24;

        // 2: ch1 inc=3 mod=7, others undisturbed
        pat1 = 14'b10101001010100;
        wr_cfg(1, 3, 7);
        g++;
        chk("t2_wr_ce", 32'(ce_out), 32'h0);
        cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            g++;
            e = (g % 6 == 0) ? 4'b1101 : 4'b0000;
            e[1] = pat1[k-1];
            chk("t2_ce", 32'(ce_out), 32'(e));
            cnt += int'(ce_out[1]);
        end
        chk("t2_cnt", 32'(cnt), 32'd6);

        // 3: ch2 1000/34921 over one full period
        wr_cfg(2, 1000, 34921);
        cnt = 0;
        last = 0;
        mins = 1000000;
        maxs = 0;
        for (int k = 1; k <= 34921; k++) begin
            tick();
            if (ce_out[2]) begin
                if (cnt > 0) begin
                    if (k - last < mins) mins = k - last;
                    if (k - last > maxs) maxs = k - last;
                end
                cnt++;
                last = k;
            end
        end
        chk("t3_cnt", 32'(cnt), 32'd1000);
        chk("t3_first_last", 32'(last), 32'd34921);
        chk("t3_min", 32'(mins), 32'd34);
        chk("t3_max", 32'(maxs), 32'd35);
        chk("t3_err", 32'(cfg_err), 32'h0);

        // 4: invalid ratios on ch3, then a valid one
        wr_cfg(3, 1, 0);
        chk("t4_err_m0", 32'(cfg_err[3]), 32'd1);
        wr_cfg(3, 5, 5);
        chk("t4_err_eq", 32'(cfg_err[3]), 32'd1);
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            cnt += int'(ce_out[3]) + int'(sq_out[3]);
        end
        chk("t4_quiet", 32'(cnt), 32'd0);
        chk("t4_err_hold", 32'(cfg_err[3]), 32'd1);
        wr_cfg(3, 1, 2);
        chk("t4_err_clr", 32'(cfg_err[3]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t4_ce3", 32'(ce_out[3]), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        // 5a: ch_en[0] low for 4 cycles delays the pulse by 4
        wr_cfg(0, 1, 6);
        tick();
        tick();
        ch_en[0] = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            tick();
            chk("t5_frozen", 32'(ce_out[0]), 32'd0);
        end
        ch_en[0] = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            tick();
            chk("t5_ce0", 32'(ce_out[0]), (k == 10) ? 32'd1 : 32'd0);
        end

        // 5b: restart together with a write of ch1 inc=2 mod=5
        sync_restart = 1'b1;
        cfg_wr  = 1'b1;
        cfg_ch  = 2'd1;
        cfg_inc = ACC_W'(2);
        cfg_mod = ACC_W'(5);
        tick();
        sync_restart = 1'b0;
        cfg_wr = 1'b0;
        chk("t5_rs_ce", 32'(ce_out), 32'h0);
        chk("t5_rs_sq", 32'(sq_out), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            e = '0;
            e[0] = (k == 6);
            e[1] = (k == 3 || k == 5 || k == 8 || k == 10);
            e[3] = (k % 2 == 0);
            chk("t5_align", 32'(ce_out), 32'(e));
            if (k == 6) chk("t5_sq6", 32'(sq_out), 32'b1001);
        end
        chk("t5_sq10", 32'(sq_out), 32'b1001);

        // 6: asynchronous reset while pulses are high
        reset = 1'b1;
        #1;
        chk("t6_ce", 32'(ce_out), 32'h0);
        chk("t6_sq", 32'(sq_out), 32'h0);
        chk("t6_err", 32'(cfg_err), 32'h0);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t6_ce_def", 32'(ce_out), (k % 6 == 0) ? 32'hF : 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
